// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
package regfile_ctrl_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [63:0] word_t;

  localparam reg_idx_t ZERO_REG = 5'd31;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is A, req[1]/gnt[1] is B.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // last_grant_q: 1 means B won the most recent contest, so A wins the next.
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        gnt          = last_grant_q ? 2'b01 : 2'b10;
        last_grant_d = ~last_grant_q;
      end
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU/load results onto the register file's
// single write port and tracks pending writes so decode can stall on operands.
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  output logic        issue_ready,
  input  logic [4:0]  rd_reg1,
  input  logic [4:0]  rd_reg2,
  output logic        stall,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [63:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [63:0] b_data,
  output logic        b_ready,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [63:0] WriteData
);

  // Handshake: a transfer happens in a cycle where valid and ready are both
  // high; ready is combinational and a requester holds valid/reg/data stable
  // until it sees ready.
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                reg_write_q, reg_write_d;
  reg_idx_t            write_register_q, write_register_d;
  word_t               write_data_q, write_data_d;

  logic [1:0] gnt;
  reg_idx_t   wb_reg;
  word_t      wb_data;
  logic       issue_accept;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({b_valid, a_valid}),
    .gnt   (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  assign issue_ready  = !issue_valid || (issue_reg == ZERO_REG) || !pending_q[issue_reg];
  assign issue_accept = issue_valid && issue_ready && (issue_reg != ZERO_REG);
  assign stall        = pending_q[rd_reg1] || pending_q[rd_reg2];

  always_comb begin
    wb_reg           = gnt[0] ? a_reg  : b_reg;
    wb_data          = gnt[0] ? a_data : b_data;
    reg_write_d      = (|gnt) && (wb_reg != ZERO_REG);
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    if (reg_write_d) begin
      write_register_d = wb_reg;
      write_data_d     = wb_data;
    end
  end

  // Clear first, then set, so an issue landing on the same edge as the write wins.
  always_comb begin
    pending_d = pending_q;
    if (reg_write_q) pending_d[write_register_q] = 1'b0;
    if (issue_accept) pending_d[issue_reg] = 1'b1;
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q        <= '0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      pending_q        <= pending_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  assign RegWrite      = reg_write_q;
  assign WriteRegister = write_register_q;
  assign WriteData     = write_data_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: scenario tasks plus a write scoreboard.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        issue_ready;
  logic [4:0]  rd_reg1, rd_reg2;
  logic        stall;
  logic        a_valid, b_valid;
  logic [4:0]  a_reg, b_reg;
  logic [63:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;

  logic [68:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        model_last_b;

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .stall(stall),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
  );

  // Advance one cycle, then retire any register-file write against the scoreboard.
  task automatic tick();
    logic [68:0] exp_w;
    @(posedge clk);
    #1;
    if (RegWrite === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_write: got reg=%0d data=%h, expected no write", WriteRegister, WriteData);
      end else begin
        exp_w = exp_q.pop_front();
        if ({WriteRegister, WriteData} !== exp_w) begin
          n_err++;
          $display("FAIL sb_write: got reg=%0d data=%h, expected reg=%0d data=%h",
                   WriteRegister, WriteData, exp_w[68:64], exp_w[63:0]);
        end
      end
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_reg = 0; rd_reg1 = 0; rd_reg2 = 0;
    a_valid = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    model_last_b = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
    n_cmp++; if (WriteRegister !== 5'd0) begin n_err++; $display("FAIL reset_wreg: got %0d expected 0", WriteRegister); end
    n_cmp++; if (WriteData !== 64'd0) begin n_err++; $display("FAIL reset_wdata: got %h expected 0", WriteData); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
  endtask

  task automatic test_single_write();
    a_valid = 1; a_reg = 5; a_data = 64'hA5;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_err++; $display("FAIL single_grant: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
    exp_q.push_back({5'd5, 64'hA5});
    tick();
    a_valid = 0;
    n_cmp++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 64'hA5) begin
      n_err++; $display("FAIL single_n1: got we=%b reg=%0d data=%h expected we=1 reg=5 data=a5", RegWrite, WriteRegister, WriteData);
    end
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_n2: got %b expected 0", RegWrite); end
  endtask

  task automatic test_stall();
    issue_valid = 1; issue_reg = 7;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL issue7_ready: got %b expected 1", issue_ready); end
    tick();
    issue_valid = 0; rd_reg1 = 7;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL stall7: got %b expected 1", stall); end
    issue_valid = 1; issue_reg = 7;
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw7: got %b expected 0", issue_ready); end
    issue_valid = 0;
    b_valid = 1; b_reg = 7; b_data = 64'h77;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL b7_grant: got %b expected 1", b_ready); end
    exp_q.push_back({5'd7, 64'h77});
    tick();
    b_valid = 0;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL stall7_n1: got %b expected 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL stall7_n2: got %b expected 0", stall); end
    rd_reg1 = 0;
  endtask

  task automatic test_back_to_back();
    logic exp_a;
    do_reset();
    a_valid = 1; a_reg = 1; a_data = 64'h1111;
    b_valid = 1; b_reg = 2; b_data = 64'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_a = model_last_b;
      n_cmp++; if (a_ready !== exp_a || b_ready !== !exp_a) begin
        n_err++; $display("FAIL rr_grant%0d: got a=%b b=%b expected a=%b b=%b", i, a_ready, b_ready, exp_a, !exp_a);
      end
      if (exp_a) exp_q.push_back({5'd1, 64'h1111});
      else       exp_q.push_back({5'd2, 64'h2222});
      model_last_b = !exp_a;
      tick();
    end
    a_valid = 0; b_valid = 0;
    tick();
  endtask

  task automatic test_zero_reg();
    issue_valid = 1; issue_reg = 31;
    a_valid = 1; a_reg = 31; a_data = 64'hA0;
    rd_reg1 = 31; rd_reg2 = 31;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL z_issue_ready: got %b expected 1", issue_ready); end
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL z_a_ready: got %b expected 1", a_ready); end
    tick();
    a_valid = 0;
    #1;
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL z_regwrite: got %b expected 0", RegWrite); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL z_stall: got %b expected 0", stall); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL z_issue_again: got %b expected 1", issue_ready); end
    issue_valid = 0;
    tick();
    rd_reg1 = 0; rd_reg2 = 0;
  endtask

  task automatic test_set_wins();
    a_valid = 1; a_reg = 9; a_data = 64'h99;
    exp_q.push_back({5'd9, 64'h99});
    tick();
    a_valid = 0;
    issue_valid = 1; issue_reg = 9;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sw_issue_ready: got %b expected 1", issue_ready); end
    tick();
    issue_valid = 0; rd_reg2 = 9;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sw_pending9: got stall=%b expected 1", stall); end
    b_valid = 1; b_reg = 9; b_data = 64'h9B;
    exp_q.push_back({5'd9, 64'h9B});
    tick();
    b_valid = 0;
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL sw_clear9: got stall=%b expected 0", stall); end
    rd_reg2 = 0;
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_reg = 3;
    tick();
    issue_reg = 4;
    tick();
    issue_valid = 0; rd_reg1 = 3; rd_reg2 = 4;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rm_stall_before: got %b expected 1", stall); end
    reset = 1;
    tick();
    reset = 0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rm_stall_after: got %b expected 0", stall); end
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rm_regwrite: got %b expected 0", RegWrite); end
    issue_valid = 1; issue_reg = 3;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rm_issue3: got %b expected 1", issue_ready); end
    issue_valid = 0; rd_reg1 = 0; rd_reg2 = 0;
    tick();
  endtask

  initial begin
    reset = 1;
    model_last_b = 1'b1;
    test_reset();
    test_single_write();
    test_stall();
    test_back_to_back();
    test_zero_reg();
    test_set_wins();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
